// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter for an asynchronous 16-bit SRAM.
// Each access runs IDLE -> SETUP -> STROBE (WAIT_CYCLES) -> FINISH, and every output is registered.
`timescale 1ns/1ps
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p1_req,
    input  logic        p0_we,
    input  logic        p1_we,
    input  logic [18:0] p0_addr,
    input  logic [18:0] p1_addr,
    input  logic [15:0] p0_wdata,
    input  logic [15:0] p1_wdata,
    output logic        p0_ack,
    output logic        p1_ack,
    output logic [15:0] p0_rdata,
    output logic [15:0] p1_rdata,
    output logic [18:0] ADR,
    output logic [15:0] DAT_OUT,
    output logic        DAT_OE,
    input  logic [15:0] DAT_IN,
    output logic        RAMCS,
    output logic        RAMOE,
    output logic        RAMWE
);
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, FINISH} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              last_grant;
    logic              we_q;
    logic [DATA_W-1:0] rdata;

    logic              any_req;
    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              acc_we;
    logic              cs_nxt;
    logic              oe_nxt;
    logic              we_nxt;
    logic              doe_nxt;
    logic              ack0_nxt;
    logic              ack1_nxt;

    // Round-robin pick: on contention the port not granted last time wins.
    assign any_req   = p0_req | p1_req;
    assign sel       = (p0_req & p1_req) ? ~last_grant : p1_req;
    assign sel_we    = sel ? p1_we    : p0_we;
    assign sel_addr  = sel ? p1_addr  : p0_addr;
    assign sel_wdata = sel ? p1_wdata : p0_wdata;
    assign acc_we    = (state == IDLE) ? sel_we : we_q;

    assign p0_rdata = rdata;
    assign p1_rdata = rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = SETUP;
            SETUP:   state_nxt = STROBE;
            STROBE:  if (cnt == '0) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobe values for the upcoming cycle, so the registered pins line up with the state.
    always_comb begin
        cs_nxt   = 1'b1;
        oe_nxt   = 1'b1;
        we_nxt   = 1'b1;
        doe_nxt  = 1'b0;
        ack0_nxt = 1'b0;
        ack1_nxt = 1'b0;
        case (state_nxt)
            SETUP: begin
                cs_nxt  = 1'b0;
                oe_nxt  = acc_we;
                doe_nxt = acc_we;
            end
            STROBE: begin
                cs_nxt  = 1'b0;
                oe_nxt  = acc_we;
                we_nxt  = ~acc_we;
                doe_nxt = acc_we;
            end
            FINISH: begin
                cs_nxt   = 1'b0;
                doe_nxt  = acc_we;
                ack0_nxt = ~last_grant;
                ack1_nxt = last_grant;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RAMCS      <= 1'b1;
            RAMOE      <= 1'b1;
            RAMWE      <= 1'b1;
            DAT_OE     <= 1'b0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            ADR        <= '0;
            DAT_OUT    <= '0;
            rdata      <= '0;
            cnt        <= '0;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
        end else begin
            RAMCS  <= cs_nxt;
            RAMOE  <= oe_nxt;
            RAMWE  <= we_nxt;
            DAT_OE <= doe_nxt;
            p0_ack <= ack0_nxt;
            p1_ack <= ack1_nxt;
            if (state == IDLE && any_req) begin
                last_grant <= sel;
                we_q       <= sel_we;
                ADR        <= sel_addr;
                DAT_OUT    <= sel_wdata;
            end
            if (state == SETUP) begin
                cnt <= CNT_LOAD;
            end else if (state == STROBE && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            // Read data is sampled on the edge that closes the final strobe cycle.
            if (state == STROBE && cnt == '0 && !we_q) begin
                rdata <= DAT_IN;
            end
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: three instances (WAIT_CYCLES 2, 1, 15) compared every cycle against
// an access-offset model, with directed, contention, random and mid-access reset stimulus.
`timescale 1ns/1ps
module tb_sram_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]       req0, req1, we0, we1;
    logic [N-1:0][18:0] addr0, addr1, adr;
    logic [N-1:0][15:0] wd0, wd1, din, rd0, rd1, dout;
    logic [N-1:0]       ack0, ack1, doe, cs, oe, wen;
    logic [N-1:0]       contend, dir_wr, dir_rd;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    function automatic int wc(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 15;
    endfunction
    // Hand-computed per instance: accept-to-ack latency, RAMWE width, accept-to-accept period.
    function automatic int lat_lit(input int g);
        return (g == 0) ? 4 : (g == 1) ? 3 : 17;
    endfunction
    function automatic int stb_lit(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 15;
    endfunction
    function automatic int per_lit(input int g);
        return (g == 0) ? 5 : (g == 1) ? 4 : 18;
    endfunction

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sram_arbiter #(.WAIT_CYCLES((g == 0) ? 2 : (g == 1) ? 1 : 15)) dut (
            .clk(clk), .rst(rst),
            .p0_req(req0[g]), .p1_req(req1[g]), .p0_we(we0[g]), .p1_we(we1[g]),
            .p0_addr(addr0[g]), .p1_addr(addr1[g]), .p0_wdata(wd0[g]), .p1_wdata(wd1[g]),
            .p0_ack(ack0[g]), .p1_ack(ack1[g]), .p0_rdata(rd0[g]), .p1_rdata(rd1[g]),
            .ADR(adr[g]), .DAT_OUT(dout[g]), .DAT_OE(doe[g]), .DAT_IN(din[g]),
            .RAMCS(cs[g]), .RAMOE(oe[g]), .RAMWE(wen[g])
        );
    end

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [W=%0d] cycle %0d: got %0h expected %0h", name, wc(g), cyc, act, exp);
        end
    endtask

    // Model state: k is the offset into the current access (0 = idle, 1 = setup, W+2 = ack cycle).
    int          k [N];
    logic        mwin [N], mlast [N], mwe [N];
    logic [18:0] madr [N];
    logic [15:0] mdout [N], mrd [N];
    int          acc_cyc [N], we_run [N], oe_run [N], gidx [N], prev_ack [N], wait0 [N], wait1 [N];

    initial begin : compare
        int w;
        logic [3:0] es;
        logic [1:0] ea;
        for (int g = 0; g < N; g++) begin
            k[g] = 0; mlast[g] = 1'b1; mwin[g] = 1'b0; mwe[g] = 1'b0;
            madr[g] = '0; mdout[g] = '0; mrd[g] = '0; acc_cyc[g] = 0;
            we_run[g] = 0; oe_run[g] = 0; gidx[g] = 0; prev_ack[g] = 0; wait0[g] = 0; wait1[g] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int g = 0; g < N; g++) begin
                w = wc(g);
                if (rst) begin
                    k[g] = 0; mlast[g] = 1'b1; mwin[g] = 1'b0; mwe[g] = 1'b0;
                    madr[g] = '0; mdout[g] = '0; mrd[g] = '0;
                    we_run[g] = 0; oe_run[g] = 0; wait0[g] = 0; wait1[g] = 0;
                end
                es = {k[g] == 0,
                      !(k[g] >= 1 && k[g] <= w + 1 && !mwe[g]),
                      !(k[g] >= 2 && k[g] <= w + 1 && mwe[g]),
                      k[g] != 0 && mwe[g]};
                ea = {k[g] == w + 2 && mwin[g], k[g] == w + 2 && !mwin[g]};
                chk("strobes {cs,oe,we,dat_oe}", g, 32'({cs[g], oe[g], wen[g], doe[g]}), 32'(es));
                chk("acks {p1,p0}", g, 32'({ack1[g], ack0[g]}), 32'(ea));
                chk("ADR", g, 32'(adr[g]), 32'(madr[g]));
                chk("DAT_OUT", g, 32'(dout[g]), 32'(mdout[g]));
                chk("p0_rdata", g, 32'(rd0[g]), 32'(mrd[g]));
                chk("p1_rdata", g, 32'(rd1[g]), 32'(mrd[g]));
                chk("RAMWE and RAMOE both low", g, 32'(!wen[g] && !oe[g]), 32'd0);
                chk("DAT_OE during RAMOE low", g, 32'(doe[g] && !oe[g]), 32'd0);
                if (!rst) begin
                    if (ack0[g] || ack1[g]) begin
                        chk("ack latency", g, 32'(cyc - acc_cyc[g]), 32'(lat_lit(g)));
                        if (contend[g]) begin
                            chk("contention grant order", g, 32'(ack1[g]), 32'(gidx[g] % 2));
                            if (gidx[g] > 0) chk("accept period", g, 32'(cyc - prev_ack[g]), 32'(per_lit(g)));
                            gidx[g]++;
                            prev_ack[g] = cyc;
                        end
                        if (dir_rd[g] && ack1[g]) chk("directed read data", g, 32'(rd1[g]), 32'h1234);
                    end
                    if (!contend[g]) gidx[g] = 0;
                    if (dir_wr[g] && k[g] == 1) begin
                        chk("directed setup ADR", g, 32'(adr[g]), 32'h1A5A5);
                        chk("directed setup DAT_OUT", g, 32'(dout[g]), 32'hBEEF);
                        chk("directed setup {cs,dat_oe}", g, 32'({cs[g], doe[g]}), 32'b01);
                    end
                    if (!wen[g]) we_run[g]++;
                    else if (we_run[g] != 0) begin
                        chk("RAMWE low width", g, 32'(we_run[g]), 32'(stb_lit(g)));
                        we_run[g] = 0;
                    end
                    if (!oe[g]) oe_run[g]++;
                    else if (oe_run[g] != 0) begin
                        chk("RAMOE low width", g, 32'(oe_run[g]), 32'(stb_lit(g) + 1));
                        oe_run[g] = 0;
                    end
                    if (ack0[g] || !req0[g]) wait0[g] = 0;
                    else begin
                        wait0[g]++;
                        chk("p0 wait bound", g, 32'(wait0[g] <= 2 * (w + 3) + 1), 32'd1);
                    end
                    if (ack1[g] || !req1[g]) wait1[g] = 0;
                    else begin
                        wait1[g]++;
                        chk("p1 wait bound", g, 32'(wait1[g] <= 2 * (w + 3) + 1), 32'd1);
                    end
                    // Advance the model using this cycle's inputs.
                    if (k[g] == 0) begin
                        if (req0[g] || req1[g]) begin
                            mwin[g]  = (req0[g] && req1[g]) ? !mlast[g] : req1[g];
                            mlast[g] = mwin[g];
                            mwe[g]   = mwin[g] ? we1[g] : we0[g];
                            madr[g]  = mwin[g] ? addr1[g] : addr0[g];
                            mdout[g] = mwin[g] ? wd1[g] : wd0[g];
                            acc_cyc[g] = cyc;
                            k[g] = 1;
                        end
                    end else if (k[g] == w + 2) begin
                        k[g] = 0;
                    end else begin
                        if (k[g] == w + 1 && !mwe[g]) mrd[g] = din[g];
                        k[g]++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access on a port; returns in the cycle after ack with req dropped.
    task automatic access(input int g, input bit port, input bit w, input logic [18:0] a, input logic [15:0] d);
        bit got;
        got = 1'b0;
        if (port) begin req1[g] = 1'b1; we1[g] = w; addr1[g] = a; wd1[g] = d; end
        else begin req0[g] = 1'b1; we0[g] = w; addr0[g] = a; wd0[g] = d; end
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            got = port ? ack1[g] : ack0[g];
        end
        tick();
        if (port) req1[g] = 1'b0; else req0[g] = 1'b0;
    endtask

    // Both ports request in the same cycle and keep requesting until each has two grants.
    task automatic contention(input int g);
        logic p0, p1;
        int n0, n1;
        n0 = 0; n1 = 0; p0 = 1'b0; p1 = 1'b0;
        contend[g] = 1'b1;
        req0[g] = 1'b1; we0[g] = 1'($urandom_range(0, 1)); addr0[g] = 19'($urandom); wd0[g] = 16'($urandom);
        req1[g] = 1'b1; we1[g] = 1'($urandom_range(0, 1)); addr1[g] = 19'($urandom); wd1[g] = 16'($urandom);
        for (int i = 0; i < 120 && (req0[g] || req1[g]); i++) begin
            tick();
            din[g] = 16'($urandom);
            if (p0) begin
                n0++;
                if (n0 == 2) req0[g] = 1'b0;
                else begin we0[g] = 1'($urandom_range(0, 1)); addr0[g] = 19'($urandom); wd0[g] = 16'($urandom); end
            end
            if (p1) begin
                n1++;
                if (n1 == 2) req1[g] = 1'b0;
                else begin we1[g] = 1'($urandom_range(0, 1)); addr1[g] = 19'($urandom); wd1[g] = 16'($urandom); end
            end
            p0 = ack0[g];
            p1 = ack1[g];
        end
        contend[g] = 1'b0;
    endtask

    initial begin : stim
        logic [N-1:0] pa0, pa1, busy0, busy1;
        rst = 1'b1;
        req0 = '0; req1 = '0; we0 = '0; we1 = '0; addr0 = '0; addr1 = '0;
        wd0 = '0; wd1 = '0; din = '0; contend = '0; dir_wr = '0; dir_rd = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int g = 0; g < N; g++) begin
            dir_wr[g] = 1'b1;
            access(g, 1'b0, 1'b1, 19'h1A5A5, 16'hBEEF);
            dir_wr[g] = 1'b0;
            din[g] = 16'h1234;
            dir_rd[g] = 1'b1;
            access(g, 1'b1, 1'b0, 19'h00010, 16'h0000);
            dir_rd[g] = 1'b0;
            contention(g);
        end

        busy0 = '0; busy1 = '0; pa0 = '0; pa1 = '0;
        for (int c = 0; c < 700; c++) begin
            tick();
            for (int g = 0; g < N; g++) begin
                din[g] = 16'($urandom);
                if (pa0[g]) busy0[g] = 1'b0;
                if (!busy0[g]) begin
                    if (c < 640 && $urandom_range(0, 2) == 0) begin
                        busy0[g] = 1'b1; req0[g] = 1'b1; we0[g] = 1'($urandom_range(0, 1));
                        addr0[g] = 19'($urandom); wd0[g] = 16'($urandom);
                    end else req0[g] = 1'b0;
                end
                if (pa1[g]) busy1[g] = 1'b0;
                if (!busy1[g]) begin
                    if (c < 640 && $urandom_range(0, 2) == 0) begin
                        busy1[g] = 1'b1; req1[g] = 1'b1; we1[g] = 1'($urandom_range(0, 1));
                        addr1[g] = 19'($urandom); wd1[g] = 16'($urandom);
                    end else req1[g] = 1'b0;
                end
                pa0[g] = ack0[g];
                pa1[g] = ack1[g];
            end
        end

        // Reset in the first STROBE cycle of a write on every instance.
        for (int g = 0; g < N; g++) begin
            req0[g] = 1'b1; we0[g] = 1'b1; addr0[g] = 19'($urandom); wd0[g] = 16'($urandom);
        end
        tick();
        tick();
        #2 rst = 1'b1;
        req0 = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int g = 0; g < N; g++) begin
            access(g, 1'b0, 1'b1, 19'($urandom), 16'($urandom));
            din[g] = 16'($urandom);
            access(g, 1'b1, 1'b0, 19'($urandom), 16'($urandom));
        end

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, giving the number of strobe cycles per access; the legal range is 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single 100 MHz clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 The block SHALL have ports p0_req / p1_req, input, 1 bit each: the access request from requester 0 / 1.
REQ-005 The block SHALL have ports p0_we / p1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-006 The block SHALL have ports p0_addr / p1_addr, input, 19 bits each: the SRAM word address.
REQ-007 The block SHALL have ports p0_wdata / p1_wdata, input, 16 bits each: the write data.
REQ-008 The block SHALL have ports p0_ack / p1_ack, output, 1 bit each: a one-cycle access-complete pulse.
REQ-009 The block SHALL have ports p0_rdata / p1_rdata, output, 16 bits each, both driven from one shared capture register.
REQ-010 The block SHALL have port ADR, output, 19 bits: the SRAM address.
REQ-011 The block SHALL have port DAT_OUT, output, 16 bits: the SRAM write data.
REQ-012 The block SHALL have port DAT_OE, output, 1 bit: the data-bus drive enable, high = drive; the tristate buffer is at top level.
REQ-013 The block SHALL have port DAT_IN, input, 16 bits: the SRAM read data.
REQ-014 The block SHALL have ports RAMCS, RAMOE and RAMWE, output, 1 bit each: the SRAM strobes, all active-low.

Function
REQ-015 The block SHALL implement states IDLE, SETUP, STROBE and FINISH, with every output registered.
REQ-016 In IDLE, if either req is high, the block SHALL select a winner, latch that port's we/addr/wdata, and go to SETUP; otherwise it stays in IDLE.
REQ-017 Arbitration SHALL be round-robin:
- if only one req is high, that port wins;
- if both are high, the port not granted last wins;
- the last-grant register resets to 1, so port 0 wins the first contention.
REQ-018 SETUP SHALL last 1 cycle, with:
- RAMCS=0 and ADR equal to the latched address;
- for a read, RAMOE=0;
- for a write, DAT_OE=1, DAT_OUT equal to the latched wdata, and RAMWE=1.
REQ-019 STROBE SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter:
- for a write, RAMWE=0;
- for a read, RAMOE=0;
- RAMCS, ADR and DAT_OUT are held.
REQ-020 On a read, the block SHALL capture DAT_IN into the rdata register at the clock edge ending the last STROBE cycle.
REQ-021 FINISH SHALL last 1 cycle, with:
- RAMWE=1 and RAMOE=1;
- RAMCS=0, ADR and DAT_OUT held, and DAT_OE still 1 for a write, giving write hold time;
- the winner's ack=1 and the other ack=0.
REQ-022 From FINISH the block SHALL go to IDLE. In IDLE, RAMCS=RAMOE=RAMWE=1, DAT_OE=0, and ADR/DAT_OUT hold their last values.
REQ-023 Ack SHALL be asserted exactly WAIT_CYCLES+2 cycles after the IDLE cycle in which the request was accepted; the accept-to-accept period is WAIT_CYCLES+3 cycles.
REQ-024 Handshake rules:
- a requester SHALL hold req, we, addr and wdata stable from assertion until its ack cycle;
- a req seen high in IDLE is always treated as a new request;
- a requester wanting no further access SHALL drop req in the cycle after ack.
REQ-025 The rdata register SHALL change only on a read capture; writes and idle cycles leave it unchanged. Rdata SHALL be valid in the ack cycle and remain valid until the next read capture.
REQ-026 Req or data changes on the non-granted port during an access SHALL have no effect until the next IDLE.
REQ-027 RAMWE=0 and RAMOE=0 SHALL never be asserted in the same cycle; DAT_OE=1 SHALL never coincide with RAMOE=0.

Reset
REQ-028 While rst=1, asynchronously:
- state=IDLE;
- RAMCS=RAMOE=RAMWE=1, DAT_OE=0;
- ADR=0, DAT_OUT=0, rdata=0;
- p0_ack=p1_ack=0;
- counter=0, last-grant=1.
REQ-029 A reset asserted mid-access SHALL abandon that access with no ack; after release, the block SHALL resume in IDLE and evaluate req on the first clock edge.

Verification
REQ-030 Single write: WAIT_CYCLES=2, p0 writes 0x1A5A5 <= 0xBEEF -> SETUP with RAMCS=0, ADR=0x1A5A5, DAT_OE=1; RAMWE=0 for exactly 2 cycles; p0_ack pulses 4 cycles after accept.
REQ-031 Single read: p1 reads 0x00010 while the SRAM model returns 0x1234 -> RAMOE=0 for 3 cycles; p1_ack=1 with p1_rdata=0x1234; RAMWE stays 1 throughout.
REQ-032 Contention: p0_req and p1_req rise in the same cycle and both are held -> the grant order is p0, p1, p0, p1; each ack goes to the matching port; consecutive accepts are 5 cycles apart.
REQ-033 Reset mid-STROBE of a write -> all strobes return to 1 and DAT_OE to 0 within the reset cycle; no ack; the first access after release completes normally.
REQ-034 WAIT_CYCLES=1 and WAIT_CYCLES=15 -> strobe widths are 1 and 15 cycles; ack latencies are 3 and 17 cycles; the REQ-027 checker is never violated.
